// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Main control FSM for a multicycle MIPS-subset datapath with
//            memory wait states and a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        zero,
    input  logic        memReady,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic [1:0]  PCSource,
    output logic        IorD,
    output logic        MemToReg,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  ALUOp,
    output logic        illegalOp,
    output logic [3:0]  state,
    output logic [31:0] instrCount
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXEC   = 4'd6;
    localparam logic [3:0] c_RWB    = 4'd7;
    localparam logic [3:0] c_BRANCH = 4'd8;
    localparam logic [3:0] c_ADDIEX = 4'd9;
    localparam logic [3:0] c_ADDIWB = 4'd10;
    localparam logic [3:0] c_JUMP   = 4'd11;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    logic [3:0]  r_state;
    logic [31:0] r_instrCount;
    logic [3:0]  w_nextState;
    logic        w_retire;

    logic        w_pcWrite;
    logic        w_pcWriteCond;
    logic [1:0]  w_pcSource;
    logic        w_iorD;
    logic        w_memToReg;
    logic        w_irWrite;
    logic        w_regWrite;
    logic        w_regDst;
    logic        w_aluSrcA;
    logic [1:0]  w_aluSrcB;
    logic        w_memRead;
    logic        w_memWrite;
    logic [1:0]  w_aluOp;
    logic        w_illegal;

    always_comb begin
        w_nextState   = c_FETCH;
        w_retire      = 1'b0;
        w_pcWrite     = 1'b0;
        w_pcWriteCond = 1'b0;
        w_pcSource    = 2'b00;
        w_iorD        = 1'b0;
        w_memToReg    = 1'b0;
        w_irWrite     = 1'b0;
        w_regWrite    = 1'b0;
        w_regDst      = 1'b0;
        w_aluSrcA     = 1'b0;
        w_aluSrcB     = 2'b00;
        w_memRead     = 1'b0;
        w_memWrite    = 1'b0;
        w_aluOp       = 2'b00;
        w_illegal     = 1'b0;

        case (r_state)
            c_FETCH: begin
                w_memRead   = 1'b1;
                w_aluSrcB   = 2'b01;
                w_irWrite   = memReady;
                w_pcWrite   = memReady;
                w_nextState = memReady ? c_DECODE : c_FETCH;
            end
            c_DECODE: begin
                w_aluSrcB = 2'b11;
                case (op)
                    c_OP_LW, c_OP_SW: w_nextState = c_MEMADR;
                    c_OP_RTYPE:       w_nextState = c_EXEC;
                    c_OP_BEQ:         w_nextState = c_BRANCH;
                    c_OP_ADDI:        w_nextState = c_ADDIEX;
                    c_OP_J:           w_nextState = c_JUMP;
                    default: begin
                        w_nextState = c_FETCH;
                        w_illegal   = 1'b1;
                    end
                endcase
            end
            c_MEMADR: begin
                w_aluSrcA   = 1'b1;
                w_aluSrcB   = 2'b10;
                w_nextState = (op == c_OP_LW) ? c_MEMRD : c_MEMWR;
            end
            c_MEMRD: begin
                w_memRead   = 1'b1;
                w_iorD      = 1'b1;
                w_nextState = memReady ? c_MEMWB : c_MEMRD;
            end
            c_MEMWB: begin
                w_regWrite = 1'b1;
                w_memToReg = 1'b1;
                w_retire   = 1'b1;
            end
            c_MEMWR: begin
                w_memWrite  = 1'b1;
                w_iorD      = 1'b1;
                w_nextState = memReady ? c_FETCH : c_MEMWR;
                w_retire    = memReady;
            end
            c_EXEC: begin
                w_aluSrcA   = 1'b1;
                w_aluOp     = 2'b10;
                w_nextState = c_RWB;
            end
            c_RWB: begin
                w_regWrite = 1'b1;
                w_regDst   = 1'b1;
                w_retire   = 1'b1;
            end
            c_BRANCH: begin
                w_aluSrcA     = 1'b1;
                w_aluOp       = 2'b01;
                w_pcWriteCond = 1'b1;
                w_pcSource    = 2'b01;
                w_pcWrite     = zero;
                w_retire      = 1'b1;
            end
            c_ADDIEX: begin
                w_aluSrcA   = 1'b1;
                w_aluSrcB   = 2'b10;
                w_nextState = c_ADDIWB;
            end
            c_ADDIWB: begin
                w_regWrite = 1'b1;
                w_retire   = 1'b1;
            end
            c_JUMP: begin
                w_pcWrite  = 1'b1;
                w_pcSource = 2'b10;
                w_retire   = 1'b1;
            end
            default: w_nextState = c_FETCH;
        endcase
    end

    // Reset overrides any pending wait state or retirement in the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_FETCH;
            r_instrCount <= 32'd0;
        end else begin
            r_state <= w_nextState;
            if (w_retire) begin
                r_instrCount <= r_instrCount + 32'd1;
            end
        end
    end

    // Side-effecting strobes are suppressed while reset is held low.
    assign PCWrite     = reset & w_pcWrite;
    assign IRWrite     = reset & w_irWrite;
    assign RegWrite    = reset & w_regWrite;
    assign MemWrite    = reset & w_memWrite;
    assign MemRead     = reset & w_memRead;
    assign illegalOp   = reset & w_illegal;
    assign PCWriteCond = w_pcWriteCond;
    assign PCSource    = w_pcSource;
    assign IorD        = w_iorD;
    assign MemToReg    = w_memToReg;
    assign RegDst      = w_regDst;
    assign ALUSrcA     = w_aluSrcA;
    assign ALUSrcB     = w_aluSrcB;
    assign ALUOp       = w_aluOp;
    assign state       = r_state;
    assign instrCount  = r_instrCount;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Directed-vector self-checking bench for multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic        zero;
    logic        memReady;
    logic        PCWrite;
    logic        PCWriteCond;
    logic [1:0]  PCSource;
    logic        IorD;
    logic        MemToReg;
    logic        IRWrite;
    logic        RegWrite;
    logic        RegDst;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  ALUOp;
    logic        illegalOp;
    logic [3:0]  state;
    logic [31:0] instrCount;

    int vectors;
    int miscompares;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .memReady   (memReady),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .PCSource   (PCSource),
        .IorD       (IorD),
        .MemToReg   (MemToReg),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ALUOp      (ALUOp),
        .illegalOp  (illegalOp),
        .state      (state),
        .instrCount (instrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: PCWrite PCWriteCond PCSource IorD MemToReg IRWrite RegWrite
    //              RegDst ALUSrcA ALUSrcB MemRead MemWrite ALUOp illegalOp
    logic [16:0] w_ctl;
    assign w_ctl = {PCWrite, PCWriteCond, PCSource, IorD, MemToReg, IRWrite, RegWrite,
                    RegDst, ALUSrcA, ALUSrcB, MemRead, MemWrite, ALUOp, illegalOp};

    localparam logic [16:0] c_FETCH_RDY  = 17'b1_0_00_0_0_1_0_0_0_01_1_0_00_0;
    localparam logic [16:0] c_FETCH_WAIT = 17'b0_0_00_0_0_0_0_0_0_01_1_0_00_0;
    localparam logic [16:0] c_FETCH_RST  = 17'b0_0_00_0_0_0_0_0_0_01_0_0_00_0;
    localparam logic [16:0] c_DECODE     = 17'b0_0_00_0_0_0_0_0_0_11_0_0_00_0;
    localparam logic [16:0] c_DECODE_ILL = 17'b0_0_00_0_0_0_0_0_0_11_0_0_00_1;
    localparam logic [16:0] c_MEMADR     = 17'b0_0_00_0_0_0_0_0_1_10_0_0_00_0;
    localparam logic [16:0] c_MEMRD      = 17'b0_0_00_1_0_0_0_0_0_00_1_0_00_0;
    localparam logic [16:0] c_MEMWB      = 17'b0_0_00_0_1_0_1_0_0_00_0_0_00_0;
    localparam logic [16:0] c_MEMWR      = 17'b0_0_00_1_0_0_0_0_0_00_0_1_00_0;
    localparam logic [16:0] c_MEMWR_RST  = 17'b0_0_00_1_0_0_0_0_0_00_0_0_00_0;
    localparam logic [16:0] c_EXEC       = 17'b0_0_00_0_0_0_0_0_1_00_0_0_10_0;
    localparam logic [16:0] c_RWB        = 17'b0_0_00_0_0_0_1_1_0_00_0_0_00_0;
    localparam logic [16:0] c_BR_TAKEN   = 17'b1_1_01_0_0_0_0_0_1_00_0_0_01_0;
    localparam logic [16:0] c_BR_NOT     = 17'b0_1_01_0_0_0_0_0_1_00_0_0_01_0;
    localparam logic [16:0] c_ADDIWB     = 17'b0_0_00_0_0_0_1_0_0_00_0_0_00_0;
    localparam logic [16:0] c_JUMP       = 17'b1_0_10_0_0_0_0_0_0_00_0_0_00_0;

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive memReady, then check state, controls and count mid-cycle.
    task automatic step(input string tag, input logic mr, input logic [3:0] expState,
                        input logic [16:0] expCtl, input logic [31:0] expCount);
        memReady = mr;
        @(negedge clk);
        checkValue({tag, ".state"}, {28'd0, state}, {28'd0, expState});
        checkValue({tag, ".ctl"},   {15'd0, w_ctl}, {15'd0, expCtl});
        checkValue({tag, ".count"}, instrCount, expCount);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        op          = 6'b000000;
        zero        = 1'b0;
        memReady    = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // memReady high during reset must not leak onto the gated strobes
        step("rst", 1'b1, 4'd0, c_FETCH_RST, 32'd0);
        reset = 1'b1;

        op = 6'b100011;
        step("lw.fetch",  1'b1, 4'd0, c_FETCH_RDY, 32'd0);
        step("lw.decode", 1'b1, 4'd1, c_DECODE,    32'd0);
        step("lw.memadr", 1'b1, 4'd2, c_MEMADR,    32'd0);
        step("lw.memrd0", 1'b0, 4'd3, c_MEMRD,     32'd0);
        step("lw.memrd1", 1'b0, 4'd3, c_MEMRD,     32'd0);
        step("lw.memrd2", 1'b1, 4'd3, c_MEMRD,     32'd0);
        step("lw.memwb",  1'b1, 4'd4, c_MEMWB,     32'd0);

        op = 6'b000000;
        step("r.fetch",  1'b1, 4'd0, c_FETCH_RDY, 32'd1);
        step("r.decode", 1'b1, 4'd1, c_DECODE,    32'd1);
        step("r.exec",   1'b1, 4'd6, c_EXEC,      32'd1);
        step("r.rwb",    1'b1, 4'd7, c_RWB,       32'd1);

        op   = 6'b000100;
        zero = 1'b1;
        step("beqT.wait",   1'b0, 4'd0, c_FETCH_WAIT, 32'd2);
        step("beqT.fetch",  1'b1, 4'd0, c_FETCH_RDY,  32'd2);
        step("beqT.decode", 1'b1, 4'd1, c_DECODE,     32'd2);
        step("beqT.branch", 1'b1, 4'd8, c_BR_TAKEN,   32'd2);

        zero = 1'b0;
        step("beqN.fetch",  1'b1, 4'd0, c_FETCH_RDY, 32'd3);
        step("beqN.decode", 1'b1, 4'd1, c_DECODE,    32'd3);
        step("beqN.branch", 1'b1, 4'd8, c_BR_NOT,    32'd3);

        op = 6'b001000;
        step("addi.fetch",  1'b1, 4'd0,  c_FETCH_RDY, 32'd4);
        step("addi.decode", 1'b1, 4'd1,  c_DECODE,    32'd4);
        step("addi.ex",     1'b1, 4'd9,  c_MEMADR,    32'd4);
        step("addi.wb",     1'b1, 4'd10, c_ADDIWB,    32'd4);

        op = 6'b111111;
        step("ill.fetch",  1'b1, 4'd0, c_FETCH_RDY,  32'd5);
        step("ill.decode", 1'b1, 4'd1, c_DECODE_ILL, 32'd5);

        op = 6'b101011;
        step("sw.fetch",  1'b1, 4'd0, c_FETCH_RDY, 32'd5);
        step("sw.decode", 1'b1, 4'd1, c_DECODE,    32'd5);
        step("sw.memadr", 1'b1, 4'd2, c_MEMADR,    32'd5);
        step("sw.memwr0", 1'b0, 4'd5, c_MEMWR,     32'd5);
        step("sw.memwr1", 1'b0, 4'd5, c_MEMWR,     32'd5);

        // Reset for a single edge while sw is still waiting on memory
        reset = 1'b0;
        step("sw.rst", 1'b0, 4'd5, c_MEMWR_RST, 32'd5);
        reset = 1'b1;

        op = 6'b000010;
        step("j.fetch",  1'b1, 4'd0,  c_FETCH_RDY,  32'd0);
        step("j.decode", 1'b1, 4'd1,  c_DECODE,     32'd0);
        step("j.jump",   1'b1, 4'd11, c_JUMP,       32'd0);
        step("j.after",  1'b0, 4'd0,  c_FETCH_WAIT, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-003 SHALL have these inputs: op (6 bits, instruction[31:26]); zero (1 bit, ALU zero flag); memReady (1 bit, memory completes the current MemRead/MemWrite access this cycle).
REQ-004 SHALL have these datapath-control outputs: PCWrite (1, effective PC enable); PCWriteCond (1); PCSource (2); IorD (1); MemToReg (1); IRWrite (1); RegWrite (1); RegDst (1); ALUSrcA (1); ALUSrcB (2).
REQ-005 SHALL have these additional outputs: MemRead (1); MemWrite (1); ALUOp (2: 00 add, 01 sub, 10 use funct); illegalOp (1); state (4, debug); instrCount (32, instructions retired).

Function
REQ-006 SHALL use Moore-style outputs decoded from state, except that memReady and zero gate PCWrite/IRWrite as stated below. Any output not listed for a state SHALL be 0.
REQ-007 Datapath encodings SHALL be:
- PCSource: 00 ALU result, 01 ALUOut, 10 jump target.
- IorD: 0 PC, 1 ALUOut.
- ALUSrcA: 0 PC, 1 A.
- ALUSrcB: 00 B, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- MemToReg: 1 memory data.
- RegDst: 1 rd.
REQ-008 Supported opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-009 States and encodings SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 SHALL go to FETCH on the next edge.
REQ-010 FETCH SHALL drive MemRead=1, ALUSrcB=01 and IRWrite=PCWrite=memReady. It SHALL stay in FETCH while memReady=0 and go to DECODE when memReady=1.
REQ-011 DECODE SHALL drive ALUSrcB=11. Next state by op: lw/sw to MEMADR, R-type to EXEC, beq to BRANCH, addi to ADDIEX, j to JUMP. Any other op goes to FETCH with illegalOp=1 for that DECODE cycle.
REQ-012 MEMADR SHALL drive ALUSrcA=1 and ALUSrcB=10. It SHALL go to MEMRD if op=lw, otherwise to MEMWR.
REQ-013 MEMRD SHALL drive MemRead=1 and IorD=1. It SHALL hold until memReady=1, then go to MEMWB.
REQ-014 MEMWB SHALL drive RegWrite=1 and MemToReg=1, then go to FETCH.
REQ-015 MEMWR SHALL drive MemWrite=1 and IorD=1. It SHALL hold until memReady=1, then go to FETCH.
REQ-016 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10, then go to RWB.
REQ-017 RWB SHALL drive RegWrite=1 and RegDst=1, then go to FETCH.
REQ-018 BRANCH SHALL drive ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01 and PCWrite=zero, then go to FETCH.
REQ-019 ADDIEX SHALL drive ALUSrcA=1 and ALUSrcB=10, then go to ADDIWB.
REQ-020 ADDIWB SHALL drive RegWrite=1, then go to FETCH.
REQ-021 JUMP SHALL drive PCWrite=1 and PCSource=10, then go to FETCH.
REQ-022 instrCount SHALL increment by 1, wrapping 0xFFFFFFFF to 0, on each transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, ADDIWB or JUMP. It SHALL NOT increment on an illegal-op return.
REQ-023 Per-instruction latency with memReady held at 1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each cycle memReady is 0 in FETCH, MEMRD or MEMWR SHALL add exactly 1 cycle.
REQ-024 MemRead and MemWrite SHALL never both be 1. No two of PCWrite, RegWrite and MemWrite from different states SHALL overlap in one cycle.

Reset
REQ-025 When reset=0 at a clk rising edge, state SHALL become FETCH and instrCount 0, overriding any in-progress wait or transition.
REQ-026 While reset=0, PCWrite, IRWrite, RegWrite, MemWrite, MemRead and illegalOp SHALL be forced to 0.
REQ-027 After reset is released, the first FETCH SHALL begin on the next cycle.

Verification
REQ-028 lw with memReady=1 in FETCH, low for 2 cycles then high in MEMRD: states 0,1,2,3,3,3,4,0; RegWrite=1 only in state 4; instrCount goes 0 to 1.
REQ-029 R-type (op=000000), memReady=1: states 0,1,6,7,0; ALUOp=10 in EXEC; RegWrite=RegDst=1 in RWB.
REQ-030 beq with zero=1: PCWrite=1 with PCSource=01 in BRANCH. Repeat with zero=0: PCWrite=0 and PCWriteCond=1. Both take 3 cycles.
REQ-031 op=111111: illegalOp=1 for exactly one cycle in DECODE, next state FETCH, instrCount unchanged.
REQ-032 sw held in MEMWR with memReady=0, then reset=0 for one edge: state 0, instrCount 0, MemWrite=0 while reset is low. After reset releases, a j instruction completes in 3 cycles with PCSource=10.
